// File: rtl/bram_arb_pkg.sv
// Shared definitions for the BRAM access arbiter: command encodings,
// controller states and default widths.
package bram_arb_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_PERF_W = 16;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_DUMP  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_DONE,
        DUMP,
        DRAIN
    } state_t;

endpackage

// File: rtl/bram_access_arbiter_if.sv
// Command port of one requester: a held request with op/address/length/data,
// answered by one-cycle ack and done pulses plus the read result.
interface bram_access_arbiter_if
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] len;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (output req, op, addr, len, wdata, input ack, done, rdata);
    modport slave  (input req, op, addr, len, wdata, output ack, done, rdata);
endinterface

// File: rtl/bram_arb_skid.sv
// Two-entry skid buffer holding {tlast, tdata} between the RAM read port and
// the stream output. The head entry drives the stream; occupancy feeds the
// read-issue gate in the controller.
module bram_arb_skid
    import bram_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic              head_valid,
    output logic [1:0]        occ
);
    logic [DATA_W:0] entry0;
    logic [DATA_W:0] entry1;
    logic [1:0]      count;

    // Push/pop bookkeeping; entry0 is always the head of the queue.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the entries are reset, unlike a RAM array, because entry0 drives
        // m_axis_tdata/tlast directly and those must read 0 out of reset.
        if (reset) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) entry0 <= {push_last, push_data};
                    else               entry1 <= {push_last, push_data};
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= {push_last, push_data};
                    end else begin
                        entry0 <= entry1;
                        entry1 <= {push_last, push_data};
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_valid = (count != 2'd0);
    assign head_data  = entry0[DATA_W-1:0];
    assign head_last  = entry0[DATA_W];
    assign occ        = count;

endmodule

// File: rtl/bram_access_arbiter.sv
// Round-robin arbiter sharing one byte-wide block RAM between two command
// requesters. Sequences single-byte reads/writes and multi-byte dumps that
// stream out on an AXI4-Stream master.
// Optional performance counters are built when BRAM_ARB_PERF_EN is defined.
module bram_access_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int PERF_W = DEF_PERF_W
) (
    input  logic                 clk,
    input  logic                 reset,
    bram_access_arbiter_if.slave r0,
    bram_access_arbiter_if.slave r1,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_we,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [DATA_W-1:0]    m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tid,
    input  logic                 m_axis_tready,
    output logic                 busy,
    input  logic                 perf_clr,
    output logic [PERF_W-1:0]    perf_gnt0,
    output logic [PERF_W-1:0]    perf_gnt1,
    output logic [PERF_W-1:0]    perf_stall
);
    state_t            state, state_nxt;
    logic              last_gnt;      // requester granted most recently
    logic              owner;         // requester owning the current command
    logic [ADDR_W-1:0] cur_addr;      // next dump read address
    logic [ADDR_W-1:0] remaining;     // dump reads still to issue
    logic              inflight;      // a RAM read returns data this cycle
    logic              inflight_last;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic              grant, grant_sel;
    op_t               gnt_op;
    logic [ADDR_W-1:0] gnt_addr, gnt_len;
    logic [DATA_W-1:0] gnt_wdata;
    logic              issue, issue_last, done_pulse;
    logic              pop, head_last;
    logic [1:0]        occ;
    logic [2:0]        fill;

    // Pick a requester in IDLE; on contention the one not granted last wins.
    always_comb begin
        grant     = 1'b0;
        grant_sel = 1'b0;
        if (state == IDLE && !reset) begin
            if (r0.req && r1.req) begin
                grant     = 1'b1;
                grant_sel = ~last_gnt;
            end else if (r0.req) begin
                grant     = 1'b1;
            end else if (r1.req) begin
                grant     = 1'b1;
                grant_sel = 1'b1;
            end
        end
    end

    assign gnt_op    = op_t'(grant_sel ? r1.op : r0.op);
    assign gnt_addr  = grant_sel ? r1.addr  : r0.addr;
    assign gnt_len   = grant_sel ? r1.len   : r0.len;
    assign gnt_wdata = grant_sel ? r1.wdata : r0.wdata;

    // Slots the skid buffer will hold after this cycle's pop, counting the
    // read already in flight; a new read may only be issued below two.
    assign pop  = m_axis_tvalid && m_axis_tready;
    assign fill = {1'b0, occ} - {2'b00, pop} + {2'b00, inflight};

    // Next state, RAM port and done pulse.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_nxt  = state;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        issue      = 1'b0;
        issue_last = 1'b0;
        done_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    mem_addr = gnt_addr;
                    case (gnt_op)
                        OP_READ:  state_nxt = RD_WAIT;
                        OP_WRITE: begin
                            mem_we    = 1'b1;
                            mem_wdata = gnt_wdata;
                            state_nxt = WR_DONE;
                        end
                        OP_DUMP: begin
                            // The first beat is read in the grant cycle itself.
                            issue      = 1'b1;
                            issue_last = (gnt_len == '0);
                            state_nxt  = (gnt_len == '0) ? DRAIN : DUMP;
                        end
                        default: begin
                            mem_addr  = '0;
                            state_nxt = WR_DONE;
                        end
                    endcase
                end
            end
            RD_WAIT, WR_DONE: begin
                done_pulse = 1'b1;
                state_nxt  = IDLE;
            end
            DUMP: begin
                if (fill < 3'd2) begin
                    issue      = 1'b1;
                    mem_addr   = cur_addr;
                    issue_last = (remaining == ADDR_W'(1));
                    if (remaining == ADDR_W'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    done_pulse = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Controller registers: state, arbitration pointer, dump progress, read results.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state         <= IDLE;
            last_gnt      <= 1'b1;
            owner         <= 1'b0;
            cur_addr      <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            state         <= state_nxt;
            inflight      <= issue;
            inflight_last <= issue_last;
            if (grant) begin
                last_gnt  <= grant_sel;
                owner     <= grant_sel;
                cur_addr  <= gnt_addr + ADDR_W'(1);
                remaining <= gnt_len;
            end else if (issue) begin
                cur_addr  <= cur_addr + ADDR_W'(1);
                remaining <= remaining - ADDR_W'(1);
            end
            if (state == RD_WAIT) begin
                if (owner) rdata1_q <= mem_rdata;
                else       rdata0_q <= mem_rdata;
            end
        end
    end

    bram_arb_skid #(.DATA_W(DATA_W)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push       (inflight),
        .push_data  (mem_rdata),
        .push_last  (inflight_last),
        .pop        (pop),
        .head_data  (m_axis_tdata),
        .head_last  (head_last),
        .head_valid (m_axis_tvalid),
        .occ        (occ)
    );

    assign m_axis_tlast = head_last;
    assign m_axis_tid   = owner;
    assign busy         = (state != IDLE);

    // Read data is forwarded during the done cycle, then held from the register.
    assign r0.ack   = grant && !grant_sel;
    assign r1.ack   = grant &&  grant_sel;
    assign r0.done  = done_pulse && !owner;
    assign r1.done  = done_pulse &&  owner;
    assign r0.rdata = (state == RD_WAIT && !owner) ? mem_rdata : rdata0_q;
    assign r1.rdata = (state == RD_WAIT &&  owner) ? mem_rdata : rdata1_q;

`ifdef BRAM_ARB_PERF_EN
    logic [PERF_W-1:0] gnt0_cnt, gnt1_cnt, stall_cnt;

    // Saturating event counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt0_cnt  <= '0;
            gnt1_cnt  <= '0;
            stall_cnt <= '0;
        end else if (perf_clr) begin
            gnt0_cnt  <= '0;
            gnt1_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (grant && !grant_sel && gnt0_cnt != '1) gnt0_cnt <= gnt0_cnt + PERF_W'(1);
            if (grant &&  grant_sel && gnt1_cnt != '1) gnt1_cnt <= gnt1_cnt + PERF_W'(1);
            if (m_axis_tvalid && !m_axis_tready && stall_cnt != '1)
                stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

    assign perf_gnt0  = gnt0_cnt;
    assign perf_gnt1  = gnt1_cnt;
    assign perf_stall = stall_cnt;
`else
    logic perf_unused;
    assign perf_unused = perf_clr;
    assign perf_gnt0   = '0;
    assign perf_gnt1   = '0;
    assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Self-checking bench for bram_access_arbiter: directed and randomized
// commands against a byte-array RAM model and a stream scoreboard.
module tb_bram_access_arbiter;
    import bram_arb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int PW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) r0_if ();
    bram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) r1_if ();

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] tdata;
    logic          tvalid, tlast, tid;
    logic          tready;
    logic          busy;
    logic          perf_clr;
    logic [PW-1:0] perf_gnt0, perf_gnt1, perf_stall;

    bram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PERF_W(PW)) dut (
        .clk           (clk),
        .reset         (reset),
        .r0            (r0_if),
        .r1            (r1_if),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tlast  (tlast),
        .m_axis_tid    (tid),
        .m_axis_tready (tready),
        .busy          (busy),
        .perf_clr      (perf_clr),
        .perf_gnt0     (perf_gnt0),
        .perf_gnt1     (perf_gnt1),
        .perf_stall    (perf_stall)
    );

    // ---------------- RAM environment and reference contents ----------------
    int unsigned   seed = 32'h1234_5678;
    logic [DW-1:0] ram        [4096];
    bit            ram_seen   [4096];
    logic [DW-1:0] model_mem  [4096];
    bit            model_seen [4096];

    function automatic logic [7:0] init_byte(input logic [11:0] a);
        logic [31:0] h;
        h = ({20'd0, a} * 32'd37) + seed;
        return h[7:0] ^ h[15:8];
    endfunction

    function automatic logic [7:0] exp_byte(input logic [11:0] a);
        return model_seen[a] ? model_mem[a] : init_byte(a);
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]      <= mem_wdata;
            ram_seen[mem_addr] <= 1'b1;
        end
        mem_rdata <= ram_seen[mem_addr] ? ram[mem_addr] : init_byte(mem_addr);
    end

    int cyc    = 0;
    int we_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int last_stalls = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ack_of(input bit who);
        return who ? r1_if.ack : r0_if.ack;
    endfunction

    function automatic logic done_of(input bit who);
        return who ? r1_if.done : r0_if.done;
    endfunction

    function automatic logic [7:0] rdata_of(input bit who);
        return who ? r1_if.rdata : r0_if.rdata;
    endfunction

    task automatic drive_req(input bit who, input logic r, input logic [1:0] op,
                             input logic [11:0] a, input logic [11:0] l, input logic [7:0] w);
        if (who) begin
            r1_if.req = r; r1_if.op = op; r1_if.addr = a; r1_if.len = l; r1_if.wdata = w;
        end else begin
            r0_if.req = r; r0_if.op = op; r0_if.addr = a; r0_if.len = l; r0_if.wdata = w;
        end
    endtask

    task automatic wait_ack(input bit who, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            #1;
            if (ack_of(who)) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("ack_seen", 32'(ok), 32'd1);
    endtask

    // One read / write / reserved command, checked cycle by cycle.
    task automatic single(input bit who, input logic [1:0] op, input logic [11:0] a, input logic [7:0] w);
        bit ok;
        int we0;
        we0 = we_cnt;
        drive_req(who, 1'b1, op, a, 12'd0, w);
        wait_ack(who, ok);
        if (!ok) begin
            drive_req(who, 1'b0, op, a, 12'd0, w);
            return;
        end
        check("grant_busy", 32'(busy), 32'd0);
        check("grant_we", 32'(mem_we), 32'(op == OP_WRITE));
        if (op != OP_RSVD) check("grant_addr", 32'(mem_addr), 32'(a));
        if (op == OP_WRITE) check("grant_wdata", 32'(mem_wdata), 32'(w));
        step();
        drive_req(who, 1'b0, op, a, 12'd0, w);
        #1;
        check("done_next", 32'(done_of(who)), 32'd1);
        check("ack_low", 32'(ack_of(who)), 32'd0);
        check("we_low", 32'(mem_we), 32'd0);
        if (op == OP_READ) check("rdata", 32'(rdata_of(who)), 32'(exp_byte(a)));
        if (op == OP_WRITE) begin
            model_mem[a]  = w;
            model_seen[a] = 1'b1;
        end
        step();
        #1;
        check("done_once", 32'(done_of(who)), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
        if (op == OP_READ) check("rdata_hold", 32'(rdata_of(who)), 32'(exp_byte(a)));
        check("we_pulses", 32'(we_cnt - we0), (op == OP_WRITE) ? 32'd1 : 32'd0);
    endtask

    // Dump command with stream scoreboard; rst_beat >= 0 resets after that many beats.
    task automatic run_dump(input bit who, input logic [11:0] a, input logic [11:0] l,
                            input bit rnd, input int rst_beat);
        bit ok;
        int ack_cyc, first_v, last_hs, done_cyc, dones, beats, extra, stalls;
        logic [7:0] pdata;
        logic plast, ptid, pstall;
        first_v = -1; last_hs = -1; done_cyc = -1;
        dones = 0; beats = 0; extra = 0; stalls = 0;
        pdata = '0; plast = 1'b0; ptid = 1'b0; pstall = 1'b0;
        tready = 1'b1;
        drive_req(who, 1'b1, OP_DUMP, a, l, 8'h00);
        wait_ack(who, ok);
        if (!ok) begin
            drive_req(who, 1'b0, OP_DUMP, a, l, 8'h00);
            return;
        end
        ack_cyc = cyc;
        check("dump_first_addr", 32'(mem_addr), 32'(a));
        check("dump_no_we", 32'(mem_we), 32'd0);
        step();
        drive_req(who, 1'b0, OP_DUMP, a, l, 8'h00);
        for (int t = 0; t < 400; t++) begin
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (tvalid && first_v < 0) first_v = cyc;
            if (pstall) begin
                check("stable_valid", 32'(tvalid), 32'd1);
                check("stable_data", 32'(tdata), 32'(pdata));
                check("stable_last", 32'(tlast), 32'(plast));
                check("stable_tid", 32'(tid), 32'(ptid));
            end
            if (done_of(who)) begin
                dones++;
                done_cyc = cyc;
            end
            if (tvalid && beats > int'(l)) extra++;
            if (tvalid && tready && beats <= int'(l)) begin
                check("beat_data", 32'(tdata), 32'(exp_byte(a + 12'(beats))));
                check("beat_last", 32'(tlast), 32'(beats == int'(l)));
                check("beat_tid", 32'(tid), 32'(who));
                beats++;
                if (beats == int'(l) + 1) last_hs = cyc;
            end
            if (tvalid && !tready) stalls++;
            pstall = tvalid && !tready;
            pdata  = tdata;
            plast  = tlast;
            ptid   = tid;
            if (rst_beat >= 0 && beats == rst_beat) begin
                reset = 1'b1;
                #1;
                check("rst_tvalid", 32'(tvalid), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done_of(who)), 32'd0);
                step();
                step();
                check("rst_no_done", 32'(done_of(who)), 32'd0);
                reset = 1'b0;
                step();
                check("rst_idle", 32'(busy), 32'd0);
                check("rst_tvalid_after", 32'(tvalid), 32'd0);
                check("rst_done_after", 32'(done_of(who)), 32'd0);
                return;
            end
            if (last_hs >= 0 && cyc >= last_hs + 3) break;
            step();
        end
        check("beat_count", 32'(beats), 32'(int'(l) + 1));
        check("extra_beats", 32'(extra), 32'd0);
        check("done_count", 32'(dones), 32'd1);
        check("done_after_last", 32'((done_cyc == last_hs) || (done_cyc == last_hs + 1)), 32'd1);
        check("idle_after_dump", 32'(busy), 32'd0);
        if (!rnd) begin
            check("first_valid_latency", 32'(first_v - ack_cyc), 32'd2);
            check("stream_rate", 32'(last_hs - first_v), 32'(l));
        end
        last_stalls = stalls;
    endtask

    // Watchdog so that a stuck run still ends.
    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, required finish before 300000 ns");
        $fatal(1);
    end

    initial begin
        logic [11:0] a_r [2];
        bit exp_who;
        logic [11:0] cur;

        tready   = 1'b1;
        perf_clr = 1'b0;
        drive_req(1'b1, 1'b0, OP_READ, 12'd0, 12'd0, 8'd0);
        drive_req(1'b0, 1'b1, OP_READ, 12'h010, 12'd0, 8'd0);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state, with a request pending that must not be acked.
        check("rst_r0_ack", 32'(r0_if.ack), 32'd0);
        check("rst_r0_done", 32'(r0_if.done), 32'd0);
        check("rst_r1_ack", 32'(r1_if.ack), 32'd0);
        check("rst_busy0", 32'(busy), 32'd0);
        check("rst_tvalid0", 32'(tvalid), 32'd0);
        check("rst_tlast0", 32'(tlast), 32'd0);
        check("rst_tid0", 32'(tid), 32'd0);
        check("rst_tdata0", 32'(tdata), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rdata", 32'({r0_if.rdata, r1_if.rdata}), 32'd0);
        check("rst_perf", 32'(perf_gnt0 | perf_gnt1 | perf_stall), 32'd0);
        drive_req(1'b0, 1'b0, OP_READ, 12'd0, 12'd0, 8'd0);
        reset = 1'b0;
        step();

        // Directed write then read-back, and a reserved op.
        single(1'b0, OP_WRITE, 12'h123, 8'hA5);
        single(1'b0, OP_READ, 12'h123, 8'h00);
        single(1'b1, OP_RSVD, 12'h055, 8'h3C);

        // Randomized single-byte traffic.
        for (int i = 0; i < 8; i++)
            single(1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) != 0) ? OP_WRITE : OP_READ,
                   12'($urandom_range(0, 4095)), 8'($urandom));
        single(1'b1, OP_WRITE, 12'hFFF, 8'h5A);
        single(1'b0, OP_WRITE, 12'h000, 8'hC3);

        // Contention: pointer restarts favouring r0, grants alternate back to back.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        a_r[0] = 12'($urandom_range(0, 4095));
        a_r[1] = 12'($urandom_range(0, 4095));
        drive_req(1'b0, 1'b1, OP_READ, a_r[0], 12'd0, 8'd0);
        drive_req(1'b1, 1'b1, OP_READ, a_r[1], 12'd0, 8'd0);
        exp_who = 1'b0;
        for (int g = 0; g < 4; g++) begin
            #1;
            check("alt_grant", 32'(ack_of(exp_who)), 32'd1);
            check("alt_other", 32'(ack_of(!exp_who)), 32'd0);
            check("alt_idle", 32'(busy), 32'd0);
            cur = a_r[exp_who];
            step();
            a_r[exp_who] = 12'($urandom_range(0, 4095));
            drive_req(exp_who, 1'b1, OP_READ, a_r[exp_who], 12'd0, 8'd0);
            #1;
            check("alt_done", 32'(done_of(exp_who)), 32'd1);
            check("alt_rdata", 32'(rdata_of(exp_who)), 32'(exp_byte(cur)));
            check("alt_no_ack_busy", 32'(r0_if.ack | r1_if.ack), 32'd0);
            step();
            exp_who = !exp_who;
        end
        drive_req(1'b0, 1'b0, OP_READ, 12'd0, 12'd0, 8'd0);
        drive_req(1'b1, 1'b0, OP_READ, 12'd0, 12'd0, 8'd0);
        step();
        step();

        // Dumps: full-rate, address wrap, single beat.
        run_dump(1'b1, 12'h000, 12'd15, 1'b0, -1);
        run_dump(1'b0, 12'hFFE, 12'd3, 1'b0, -1);
        run_dump(1'b1, 12'($urandom_range(0, 4095)), 12'd0, 1'b0, -1);

        // Backpressured dump with counters cleared just before it.
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        run_dump(1'b0, 12'($urandom_range(0, 4095)), 12'd7, 1'b1, -1);
`ifdef BRAM_ARB_PERF_EN
        check("perf_stall", 32'(perf_stall), 32'(last_stalls));
        check("perf_gnt0", 32'(perf_gnt0), 32'd1);
        check("perf_gnt1", 32'(perf_gnt1), 32'd0);
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        #1;
        check("perf_clr", 32'(perf_gnt0 | perf_gnt1 | perf_stall), 32'd0);
`else
        check("perf_tied", 32'(perf_gnt0 | perf_gnt1 | perf_stall), 32'd0);
`endif

        // Reset in the middle of a dump, then normal service resumes.
        run_dump(1'b1, 12'h200, 12'd15, 1'b0, 5);
        single(1'b0, OP_READ, 12'h123, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_access_arbiter.md
Name: bram_access_arbiter

Overview:
- Shares one 4 KB byte-wide block RAM between two command requesters: r0 (HPS CSR command path) and r1 (FPGA-side client).
- Round-robin arbitration; sequences single-byte read/write and multi-byte dump commands.
- Dumps stream out on an AXI4-Stream master with correct tlast and full tready backpressure.
- Sits between the CSR/command logic and the RAM plus downstream stream sink.

Parameters:
- ADDR_W, 12, RAM address width (4096 bytes).
- DATA_W, 8, RAM/stream data width.
- PERF_W, 16, width of optional performance counters.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- r0_req / r1_req  in  1  command request; held until ack.
- r0_op / r1_op  in  2  00 read, 01 write, 10 dump, 11 reserved.
- r0_addr / r1_addr  in  ADDR_W  byte address, or dump start address.
- r0_len / r1_len  in  ADDR_W  dump beat count minus 1.
- r0_wdata / r1_wdata  in  DATA_W  write byte.
- r0_ack / r1_ack  out  1  one-cycle pulse: command accepted.
- r0_done / r1_done  out  1  one-cycle pulse: command complete.
- r0_rdata / r1_rdata  out  DATA_W  read result; valid from the done pulse until the next done for that requester.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid 1 cycle after mem_addr.
- m_axis_tdata  out  DATA_W  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tlast  out  1  asserted on the final dump beat.
- m_axis_tid  out  1  index of the requester owning the dump.
- m_axis_tready  in  1  stream ready.
- busy  out  1  high whenever the state is not IDLE.
- perf_clr  in  1  synchronous clear of performance counters.
- perf_gnt0, perf_gnt1, perf_stall  out  PERF_W  performance counters.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer favours r0.
  - Skid buffer empty.
- States: IDLE, RD_WAIT, WR_DONE, DUMP, DRAIN.
- Arbitration (IDLE only):
  - Exactly one req high: grant that requester.
  - Both high: grant the requester not granted last.
  - Grant cycle: ack pulse, command latched, pointer updated.
- Read:
  - Grant cycle drives mem_addr; next state RD_WAIT.
  - RD_WAIT captures mem_rdata into rN_rdata and pulses done (done 1 cycle after ack); next state IDLE.
- Write:
  - Grant cycle drives mem_addr/mem_wdata with mem_we=1.
  - WR_DONE pulses done (1 cycle after ack); next state IDLE.
- Reserved op: ack, no RAM access, done next cycle via WR_DONE.
- Back-to-back commands: a new grant is possible in the cycle after done.
- Dump:
  - Grant cycle latches start and remaining=len; next state DUMP.
  - A read is issued each cycle while beats remain and (buffer occupancy + in-flight read) < 2.
  - Read data enters the 2-entry skid buffer; its head drives tdata/tvalid.
- Dump addressing:
  - Address increments modulo 2^ADDR_W, so 0xFFF+1 wraps to 0x000.
  - len=0 produces exactly one beat, with tlast set.
- Dump completion:
  - Once the last read is issued, next state DRAIN.
  - After the tlast beat handshakes, done pulses and next state IDLE.
- AXIS rules:
  - tdata/tlast/tid are stable while tvalid && !tready.
  - tvalid never drops without a handshake.
  - With tready held high: first tvalid 2 cycles after ack, then 1 beat/cycle.
- RAM ownership: the non-owning requester is never acked until IDLE.
- Reset mid-operation: outputs clear immediately (asynchronous), buffer is flushed, no done pulse.

Optional Feature:
- Macro: BRAM_ARB_PERF_EN.
- Defined:
  - perf_gnt0/perf_gnt1 count grants per requester.
  - perf_stall counts cycles of tvalid && !tready.
  - All counters saturate at all-ones.
  - perf_clr zeroes the counters; clear has priority over increment.
- Undefined: the perf ports remain but are tied to 0; no counter logic is built.

Decomposition:
- Package bram_arb_pkg:
  - Op encodings OP_READ/OP_WRITE/OP_DUMP/OP_RSVD.
  - State enum.
  - Default widths.
- Sub-module bram_arb_skid: 2-entry buffer carrying {tdata, tlast}, with occupancy output used for read-issue gating.

Test Plan:
- r0 writes 0xA5 to 0x123, then reads 0x123 → r0_ack, r0_done 1 cycle later, r0_rdata=0xA5; mem_we high exactly one cycle.
- r0 and r1 request reads simultaneously, repeated 4 times → grants alternate r0, r1, r0, r1; each acks only when IDLE.
- r1 dumps addr 0x000, len 15, tready=1 → 16 beats, data matches RAM, tlast on beat 16 only, tid=1, r1_done after the last handshake.
- Dump addr 0xFFE, len 3 → beats come from 0xFFE, 0xFFF, 0x000, 0x001 (wrap).
- Dump len 7 with tready random (~50%) → data/tlast stable across stalls, no loss or duplication; with PERF_EN, perf_stall equals the stalled cycle count.
- Assert reset mid-dump at beat 5 → tvalid=0 immediately, busy=0, no done; a following r0 read completes normally.
